// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the hazard/redirect requests coming from the pipeline stages and the
// stall/flush/redirect controls going back to them.
//   master : pipeline side, drives the requests, receives the controls
//   slave  : pipe_ctrl side, receives the requests, drives the controls
// Requests : stallreq_id, div_start, mem_wait, branch_valid, branch_target,
//            exc_valid, eret_valid, epc_in
// Controls : stall[5:0] {wb,mem,ex,id,if,pc}, flush, pc_stall, if_branch,
//            target_pc, div_busy, div_done
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              stallreq_id;
    logic              div_start;
    logic              mem_wait;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic              exc_valid;
    logic              eret_valid;
    logic [ADDR_W-1:0] epc_in;

    logic [5:0]        stall;
    logic              flush;
    logic              pc_stall;
    logic              if_branch;
    logic [ADDR_W-1:0] target_pc;
    logic              div_busy;
    logic              div_done;

    modport master (
        output stallreq_id, div_start, mem_wait, branch_valid, branch_target,
               exc_valid, eret_valid, epc_in,
        input  stall, flush, pc_stall, if_branch, target_pc, div_busy, div_done
    );

    modport slave (
        input  stallreq_id, div_start, mem_wait, branch_valid, branch_target,
               exc_valid, eret_valid, epc_in,
        output stall, flush, pc_stall, if_branch, target_pc, div_busy, div_done
    );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush/redirect controller for the 5-stage pipeline. Merges
// load-use, multi-cycle divide, memory-wait, branch, exception and eret
// requests into one per-stage stall vector, a flush strobe and at most one PC
// redirect per cycle. All outputs are combinational from the registered state
// and the current requests so the PC block can act on the same edge.
// Ports:
//   clk   : clock
//   rst   : synchronous, active-high reset
//   ctrl  : pipe_ctrl_if.slave (requests in, stall/flush/redirect out)
// Parameters:
//   ADDR_W     : PC / target width
//   DIV_CYCLES : EX stall cycles per divide (>= 2)
//   EXC_VECTOR : exception handler address
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter int                DIV_CYCLES = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_0020)
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  ctrl
);

    localparam int               CNT_W    = $clog2(DIV_CYCLES);
    // The issue cycle is stalled too, so loading DIV_CYCLES-1 gives exactly
    // DIV_CYCLES stalled cycles before the done cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [5:0] STALL_MEM = 6'b011111;
    localparam logic [5:0] STALL_DIV = 6'b001111;
    localparam logic [5:0] STALL_LU  = 6'b000111;

    typedef enum logic {
        RUN = 1'b0,
        DIV = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pendValid_q, pendValid_d;
    logic [ADDR_W-1:0] pendTarget_q, pendTarget_d;

    logic [5:0]        stallVec;
    logic              flush;
    logic              ifBranch;
    logic [ADDR_W-1:0] targetPc;
    logic              divBusy;
    logic              divDone;
    logic              divStall;

    // Next-state and output logic. Exceptions and erets override everything:
    // they abort a divide, drop any buffered branch and redirect the PC.
    // Otherwise stall sources are OR-ed together and a redirect is only issued
    // in a cycle where the PC is free to load; a buffered branch is issued
    // before a fresh one, and a branch that cannot be issued is buffered.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pendValid_d  = pendValid_q;
        pendTarget_d = pendTarget_q;
        stallVec     = '0;
        flush        = 1'b0;
        ifBranch     = 1'b0;
        targetPc     = '0;
        divBusy      = 1'b0;
        divDone      = 1'b0;
        divStall     = 1'b0;

        if (rst) begin
            flush = 1'b1;
        end else if (ctrl.exc_valid || ctrl.eret_valid) begin
            flush       = 1'b1;
            ifBranch    = 1'b1;
            targetPc    = ctrl.exc_valid ? EXC_VECTOR : ctrl.epc_in;
            divBusy     = (state_q == DIV);
            state_d     = RUN;
            cnt_d       = '0;
            pendValid_d = 1'b0;
        end else begin
            divBusy = (state_q == DIV);
            case (state_q)
                RUN: begin
                    if (ctrl.div_start) begin
                        divStall = 1'b1;
                        state_d  = DIV;
                        cnt_d    = CNT_LOAD;
                    end
                end
                DIV: begin
                    // Counter keeps running under mem_wait; only the final
                    // release waits for memory.
                    if (cnt_q != '0) begin
                        divStall = 1'b1;
                        cnt_d    = cnt_q - 1'b1;
                    end else if (!ctrl.mem_wait) begin
                        divDone = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase

            stallVec = (ctrl.mem_wait   ? STALL_MEM : 6'b0)
                     | (divStall        ? STALL_DIV : 6'b0)
                     | (ctrl.stallreq_id ? STALL_LU  : 6'b0);

            if (!stallVec[0]) begin
                if (pendValid_q) begin
                    ifBranch    = 1'b1;
                    targetPc    = pendTarget_q;
                    pendValid_d = 1'b0;
                end else if (ctrl.branch_valid) begin
                    ifBranch = 1'b1;
                    targetPc = ctrl.branch_target;
                end
            end

            if (ctrl.branch_valid && (stallVec[0] || pendValid_q)) begin
                pendValid_d  = 1'b1;
                pendTarget_d = ctrl.branch_target;
            end
        end
    end

    assign ctrl.stall     = stallVec;
    assign ctrl.flush     = flush;
    assign ctrl.pc_stall  = stallVec[0];
    assign ctrl.if_branch = ifBranch;
    assign ctrl.target_pc = targetPc;
    assign ctrl.div_busy  = divBusy;
    assign ctrl.div_done  = divDone;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            pendValid_q  <= 1'b0;
            pendTarget_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pendValid_q  <= pendValid_d;
            pendTarget_q <= pendTarget_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Drives pipe_ctrl with directed scenarios and then random request mixes.
// A behavioural reference model (divide as "stalled cycles remaining",
// pending branch as a flag/target pair) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int          ADDR_W = 32;
    localparam int          NDIV   = 4;
    localparam logic [31:0] EXCV   = 32'h0000_0020;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    pipe_ctrl #(
        .ADDR_W    (ADDR_W),
        .DIV_CYCLES(NDIV),
        .EXC_VECTOR(EXCV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mDivActive = 0;
    int          mDivLeft   = 0;
    bit          mPend      = 0;
    logic [31:0] mPendT     = '0;

    // Last sampled DUT outputs, for scenario-level checks
    logic [5:0]  obsStall;
    logic        obsIfb;
    logic [31:0] obsTgt;
    logic        obsDone;
    logic        obsFlush;
    logic        obsBusy;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive requests after the falling edge, compare all
    // outputs against the model, then advance the model across the rising edge.
    task automatic applyStimulus(input bit r, input bit sreq, input bit ds,
                                 input bit mw, input bit bv, input logic [31:0] bt,
                                 input bit ex, input bit er, input logic [31:0] epc);
        logic [5:0]  eStall;
        logic        eFlush, eIfb, eBusy, eDone, divStallNow;
        logic [31:0] eTgt;

        @(negedge clk);
        rst               = r;
        bus.stallreq_id   = sreq;
        bus.div_start     = ds;
        bus.mem_wait      = mw;
        bus.branch_valid  = bv;
        bus.branch_target = bt;
        bus.exc_valid     = ex;
        bus.eret_valid    = er;
        bus.epc_in        = epc;
        #2;

        eStall = '0; eFlush = 0; eIfb = 0; eTgt = '0; eBusy = 0; eDone = 0;
        divStallNow = 0;
        if (r) begin
            eFlush = 1;
        end else if (ex || er) begin
            eFlush = 1;
            eIfb   = 1;
            eTgt   = ex ? EXCV : epc;
            eBusy  = mDivActive;
        end else begin
            eBusy       = mDivActive;
            divStallNow = (!mDivActive && ds) || (mDivActive && mDivLeft > 0);
            eDone       = mDivActive && (mDivLeft == 0) && !mw;
            if (mw)          eStall |= 6'b011111;
            if (divStallNow) eStall |= 6'b001111;
            if (sreq)        eStall |= 6'b000111;
            if (eStall == 0) begin
                if (mPend) begin
                    eIfb = 1; eTgt = mPendT;
                end else if (bv) begin
                    eIfb = 1; eTgt = bt;
                end
            end
        end

        obsStall = bus.stall;
        obsIfb   = bus.if_branch;
        obsTgt   = bus.target_pc;
        obsDone  = bus.div_done;
        obsFlush = bus.flush;
        obsBusy  = bus.div_busy;

        checkOutput("stall",     64'(bus.stall),     64'(eStall));
        checkOutput("flush",     64'(bus.flush),     64'(eFlush));
        checkOutput("pc_stall",  64'(bus.pc_stall),  64'(eStall[0]));
        checkOutput("if_branch", 64'(bus.if_branch), 64'(eIfb));
        checkOutput("target_pc", 64'(bus.target_pc), 64'(eTgt));
        checkOutput("div_busy",  64'(bus.div_busy),  64'(eBusy));
        checkOutput("div_done",  64'(bus.div_done),  64'(eDone));

        @(posedge clk);
        if (r || ex || er) begin
            mDivActive = 0; mDivLeft = 0; mPend = 0;
        end else begin
            if (!mDivActive && ds) begin
                mDivActive = 1;
                mDivLeft   = NDIV - 1;
            end else if (mDivActive) begin
                if (mDivLeft > 0)  mDivLeft--;
                else if (!mw)      mDivActive = 0;
            end
            if (bv && (eStall[0] || mPend)) begin
                mPend = 1; mPendT = bt;
            end else if (eStall == 0) begin
                mPend = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0,0,0,0,0,'0,0,0,'0);
    endtask

    int divStalls;
    int doneAt;
    int doneCount;

    initial begin
        rst = 1; bus.stallreq_id = 0; bus.div_start = 0; bus.mem_wait = 0;
        bus.branch_valid = 0; bus.branch_target = '0; bus.exc_valid = 0;
        bus.eret_valid = 0; bus.epc_in = '0;

        // Reset for two cycles, then release
        applyStimulus(1,0,0,0,0,'0,0,0,'0);
        checkOutput("rst_flush", 64'(obsFlush), 64'd1);
        applyStimulus(1,0,0,0,0,'0,0,0,'0);
        idle(1);
        checkOutput("rel_stall", 64'(obsStall), 64'd0);
        checkOutput("rel_flush", 64'(obsFlush), 64'd0);
        checkOutput("rel_busy",  64'(obsBusy),  64'd0);

        // Divide: exactly NDIV stalled cycles, done in the next one
        divStalls = 0; doneAt = -1;
        for (int i = 0; i < NDIV + 3; i++) begin
            applyStimulus(0,0,(i == 0),0,0,'0,0,0,'0);
            if (obsStall == 6'b001111) divStalls++;
            if (obsDone && doneAt < 0) doneAt = i;
        end
        checkOutput("div_stall_cycles", 64'(divStalls), 64'(NDIV));
        checkOutput("div_done_cycle",   64'(doneAt),    64'(NDIV));

        // Divide finishing under mem_wait: done held off until memory is ready
        applyStimulus(0,0,1,0,0,'0,0,0,'0);
        idle(NDIV - 1);
        doneCount = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0,0,0,1,0,'0,0,0,'0);
            checkOutput("memwait_stall", 64'(obsStall), 64'h1f);
            if (obsDone) doneCount++;
        end
        checkOutput("memwait_no_done", 64'(doneCount), 64'd0);
        idle(1);
        checkOutput("done_after_wait", 64'(obsDone), 64'd1);

        // Branch during mem_wait is held and issued once unstalled
        applyStimulus(0,0,0,1,1,32'h100,0,0,'0);
        checkOutput("br_held0", 64'(obsIfb), 64'd0);
        applyStimulus(0,0,0,1,0,'0,0,0,'0);
        checkOutput("br_held1", 64'(obsIfb), 64'd0);
        idle(1);
        checkOutput("br_issue",  64'(obsIfb), 64'd1);
        checkOutput("br_target", 64'(obsTgt), 64'h100);

        // Exception mid-divide with a buffered branch: everything dropped
        applyStimulus(0,0,1,0,0,'0,0,0,'0);
        applyStimulus(0,0,0,0,1,32'h200,0,0,'0);
        applyStimulus(0,0,0,0,0,'0,1,0,'0);
        checkOutput("exc_flush",  64'(obsFlush), 64'd1);
        checkOutput("exc_target", 64'(obsTgt),   64'h20);
        idle(1);
        checkOutput("exc_busy_after", 64'(obsBusy), 64'd0);
        checkOutput("exc_pend_drop",  64'(obsIfb),  64'd0);

        // Exception beats eret; eret alone returns to epc
        applyStimulus(0,0,0,0,0,'0,1,1,32'h40);
        checkOutput("exc_over_eret", 64'(obsTgt), 64'h20);
        applyStimulus(0,0,0,0,0,'0,0,1,32'h40);
        checkOutput("eret_target", 64'(obsTgt),   64'h40);
        checkOutput("eret_flush",  64'(obsFlush), 64'd1);

        // Random request mixes
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 149) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0),
                          $urandom & 32'hffff_fffc,
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 39) == 0),
                          $urandom & 32'hffff_fffc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
